// File: rtl/dmem_port_pkg.sv
// dmem_port_pkg: shared access-mode, state and byte-lane encodings for the data-memory port and MEM stage
package dmem_port_pkg;
    localparam logic [1:0] MODE_WORD = 2'd0;
    localparam logic [1:0] MODE_HALF = 2'd1;
    localparam logic [1:0] MODE_BYTE = 2'd2;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;
    localparam logic [3:0] LANE_ALL  = 4'b1111;
    localparam logic [3:0] LANE_HI   = 4'b1100;
    localparam logic [3:0] LANE_LO   = 4'b0011;
    localparam logic [3:0] LANE_BYTE = 4'b1000;
endpackage

// File: rtl/dmem_port_if.sv
// dmem_port_if: wait-state data memory bus between dmem_port (master) and the memory (slave)
interface dmem_port_if #(parameter int AW = 32);
    logic [AW-1:0] busAddr;
    logic [31:0]   busWData;
    logic [3:0]    busByteEn;
    logic          busRead;
    logic          busWrite;
    logic          busWait;
    logic [31:0]   busRData;
    modport master(output busAddr, busWData, busByteEn, busRead, busWrite, input busWait, busRData);
    modport slave(input busAddr, busWData, busByteEn, busRead, busWrite, output busWait, busRData);
endinterface

// File: rtl/dmem_port_store_align.sv
// store_align: big-endian lane enables, replicated store data and alignment check for one request
module store_align
    import dmem_port_pkg::*;
(
    input  logic [1:0]  AccessMode,
    input  logic [1:0]  addr,
    input  logic [31:0] storeData,
    output logic [3:0]  byteEn,
    output logic [31:0] wdata,
    output logic        misaligned
);
    logic is_half, is_byte;
    assign is_half = AccessMode == MODE_HALF;
    assign is_byte = AccessMode == MODE_BYTE;
    // reserved mode 3 falls through to word handling
    assign misaligned = is_half ? addr[0] : (is_byte ? 1'b0 : |addr);
    assign byteEn = is_byte ? LANE_BYTE >> addr : (is_half ? (addr[1] ? LANE_LO : LANE_HI) : LANE_ALL);
    assign wdata = is_byte ? {4{storeData[7:0]}} : (is_half ? {2{storeData[15:0]}} : storeData);
endmodule

// File: rtl/dmem_port.sv
// dmem_port: aligns EX load/store requests, runs the wait-state bus handshake with timeout,
// and hands the raw read word and its address to MEM
module dmem_port
    import dmem_port_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int AW = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           MemRead,
    input  logic           MemWrite,
    input  logic [1:0]     AccessMode,
    input  logic [AW-1:0]  addr,
    input  logic [31:0]    storeData,
    output logic           stall,
    dmem_port_if.master    bus,
    output logic [31:0]    dataAddr,
    output logic [31:0]    dataIn,
    output logic           loadDone,
    output logic           addrErr,
    output logic           busErr
);
    logic [0:0]    state;
    logic [15:0]   cnt;
    logic [AW-1:0] req_addr;
    logic [3:0]    byte_en;
    logic [31:0]   wdata;
    logic          misaligned, req, start, done, abort;

    store_align u_align (
        .AccessMode (AccessMode),
        .addr       (addr[1:0]),
        .storeData  (storeData),
        .byteEn     (byte_en),
        .wdata      (wdata),
        .misaligned (misaligned)
    );

    assign req   = MemRead | MemWrite;
    assign start = state == IDLE && req && !misaligned;
    assign done  = state == ACCESS && !bus.busWait;
    assign abort = state == ACCESS && bus.busWait && cnt == 16'(TIMEOUT - 1);
    // the abort cycle releases the pipeline just like a normal completion
    assign stall = start || (state == ACCESS && bus.busWait && !abort);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            req_addr      <= '0;
            bus.busAddr   <= '0;
            bus.busWData  <= '0;
            bus.busByteEn <= '0;
            bus.busRead   <= 1'b0;
            bus.busWrite  <= 1'b0;
            dataAddr      <= '0;
            dataIn        <= '0;
            loadDone      <= 1'b0;
            addrErr       <= 1'b0;
            busErr        <= 1'b0;
        end else begin
            loadDone <= done && bus.busRead;
            addrErr  <= state == IDLE && req && misaligned;
            busErr   <= abort;
            if (start) begin
                state         <= ACCESS;
                cnt           <= '0;
                req_addr      <= addr;
                bus.busAddr   <= {addr[AW-1:2], 2'b00};
                bus.busWData  <= MemWrite ? wdata : 32'd0;
                bus.busByteEn <= byte_en;
                bus.busRead   <= !MemWrite;
                bus.busWrite  <= MemWrite;
            end else if (done || abort) begin
                state        <= IDLE;
                bus.busRead  <= 1'b0;
                bus.busWrite <= 1'b0;
                if (done && bus.busRead) begin
                    dataIn   <= bus.busRData;
                    dataAddr <= 32'(req_addr);
                end
            end else if (state == ACCESS) begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: directed checks of dmem_port alignment, handshake, timeout and reset behaviour
module tb_dmem_port;
    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite;
    logic [1:0]  AccessMode;
    logic [31:0] addr, storeData;
    logic        stall, loadDone, addrErr, busErr;
    logic [31:0] dataAddr, dataIn;
    int          n_checks = 0;
    int          n_fail = 0;

    dmem_port_if #(.AW(32)) bus ();

    dmem_port #(.TIMEOUT(4), .AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .AccessMode (AccessMode),
        .addr       (addr),
        .storeData  (storeData),
        .stall      (stall),
        .bus        (bus),
        .dataAddr   (dataAddr),
        .dataIn     (dataIn),
        .loadDone   (loadDone),
        .addrErr    (addrErr),
        .busErr     (busErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; AccessMode = 2'd0;
        addr = 32'd0; storeData = 32'd0; bus.busWait = 1'b0; bus.busRData = 32'd0;
        tick(); tick();
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_strobes", {30'd0, bus.busRead, bus.busWrite}, 0);
        chk("rst_pulses", {29'd0, loadDone, addrErr, busErr}, 0);
        chk("rst_busaddr", bus.busAddr, 0);
        chk("rst_wdata", bus.busWData, 0);
        chk("rst_byteen", {28'd0, bus.busByteEn}, 0);
        chk("rst_datain", dataIn, 0);
        chk("rst_dataaddr", dataAddr, 0);
        reset = 1'b0;
        tick();
        // word load, zero wait states
        MemRead = 1'b1; AccessMode = 2'd0; addr = 32'h100; bus.busRData = 32'hDEADBEEF;
        #1 chk("wl_req_stall", {31'd0, stall}, 1);
        tick();
        MemRead = 1'b0;
        #1;
        chk("wl_busread", {31'd0, bus.busRead}, 1);
        chk("wl_busaddr", bus.busAddr, 32'h100);
        chk("wl_byteen", {28'd0, bus.busByteEn}, 32'hF);
        chk("wl_wdata", bus.busWData, 0);
        chk("wl_acc_stall", {31'd0, stall}, 0);
        tick();
        chk("wl_busread_drop", {31'd0, bus.busRead}, 0);
        chk("wl_loaddone", {31'd0, loadDone}, 1);
        chk("wl_datain", dataIn, 32'hDEADBEEF);
        chk("wl_dataaddr", dataAddr, 32'h100);
        chk("wl_stall_after", {31'd0, stall}, 0);
        // byte store with three wait states, started the cycle after completion
        MemWrite = 1'b1; AccessMode = 2'd2; addr = 32'h203; storeData = 32'h12345678; bus.busWait = 1'b1;
        #1 chk("bs_req_stall", {31'd0, stall}, 1);
        tick();
        chk("bs_loaddone_clear", {31'd0, loadDone}, 0);
        chk("bs_buswrite", {31'd0, bus.busWrite}, 1);
        chk("bs_busread", {31'd0, bus.busRead}, 0);
        chk("bs_busaddr", bus.busAddr, 32'h200);
        chk("bs_byteen", {28'd0, bus.busByteEn}, 32'h1);
        chk("bs_wdata", bus.busWData, 32'h78787878);
        chk("bs_stall_w1", {31'd0, stall}, 1);
        tick();
        chk("bs_stall_w2", {31'd0, stall}, 1);
        tick();
        chk("bs_stall_w3", {31'd0, stall}, 1);
        chk("bs_buswrite_w3", {31'd0, bus.busWrite}, 1);
        tick();
        bus.busWait = 1'b0; MemWrite = 1'b0;
        #1;
        chk("bs_buswrite_last", {31'd0, bus.busWrite}, 1);
        chk("bs_stall_last", {31'd0, stall}, 0);
        chk("bs_busaddr_held", bus.busAddr, 32'h200);
        tick();
        chk("bs_buswrite_drop", {31'd0, bus.busWrite}, 0);
        chk("bs_no_loaddone", {31'd0, loadDone}, 0);
        chk("bs_datain_kept", dataIn, 32'hDEADBEEF);
        chk("bs_no_buserr", {31'd0, busErr}, 0);
        // half load at offset 2
        MemRead = 1'b1; AccessMode = 2'd1; addr = 32'h102; bus.busRData = 32'hCAFEF00D;
        tick();
        MemRead = 1'b0;
        #1;
        chk("hl_byteen", {28'd0, bus.busByteEn}, 32'h3);
        chk("hl_busaddr", bus.busAddr, 32'h100);
        chk("hl_busread", {31'd0, bus.busRead}, 1);
        tick();
        chk("hl_loaddone", {31'd0, loadDone}, 1);
        chk("hl_datain", dataIn, 32'hCAFEF00D);
        chk("hl_dataaddr", dataAddr, 32'h102);
        // misaligned half then misaligned word, back to back
        MemRead = 1'b1; AccessMode = 2'd1; addr = 32'h101;
        #1 chk("mh_stall", {31'd0, stall}, 0);
        tick();
        AccessMode = 2'd0; addr = 32'h102;
        #1;
        chk("mh_addrerr", {31'd0, addrErr}, 1);
        chk("mh_no_busread", {31'd0, bus.busRead}, 0);
        chk("mw_stall", {31'd0, stall}, 0);
        tick();
        MemRead = 1'b0;
        #1;
        chk("mw_addrerr", {31'd0, addrErr}, 1);
        chk("mw_no_busread", {31'd0, bus.busRead}, 0);
        tick();
        chk("mw_addrerr_clear", {31'd0, addrErr}, 0);
        // timeout abort with busWait stuck high
        MemRead = 1'b1; AccessMode = 2'd0; addr = 32'h300; bus.busWait = 1'b1; bus.busRData = 32'h11111111;
        tick();
        chk("to_busread", {31'd0, bus.busRead}, 1);
        chk("to_stall_c0", {31'd0, stall}, 1);
        tick();
        chk("to_stall_c1", {31'd0, stall}, 1);
        tick();
        chk("to_stall_c2", {31'd0, stall}, 1);
        chk("to_no_buserr_early", {31'd0, busErr}, 0);
        tick();
        MemRead = 1'b0;
        #1;
        chk("to_stall_abort", {31'd0, stall}, 0);
        chk("to_busread_abort", {31'd0, bus.busRead}, 1);
        tick();
        chk("to_busread_drop", {31'd0, bus.busRead}, 0);
        chk("to_buserr", {31'd0, busErr}, 1);
        chk("to_datain_kept", dataIn, 32'hCAFEF00D);
        chk("to_no_loaddone", {31'd0, loadDone}, 0);
        bus.busWait = 1'b0;
        tick();
        chk("to_buserr_once", {31'd0, busErr}, 0);
        // read and write together is a write
        MemRead = 1'b1; MemWrite = 1'b1; AccessMode = 2'd0; addr = 32'h10; storeData = 32'hA5A5A5A5;
        tick();
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        chk("rw_buswrite", {31'd0, bus.busWrite}, 1);
        chk("rw_no_busread", {31'd0, bus.busRead}, 0);
        chk("rw_wdata", bus.busWData, 32'hA5A5A5A5);
        tick();
        chk("rw_no_loaddone", {31'd0, loadDone}, 0);
        chk("rw_dataaddr_kept", dataAddr, 32'h102);
        // reset during ACCESS abandons the transfer
        MemRead = 1'b1; addr = 32'h400; bus.busWait = 1'b1;
        tick();
        MemRead = 1'b0;
        #1 chk("ra_busread", {31'd0, bus.busRead}, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ra_strobes", {30'd0, bus.busRead, bus.busWrite}, 0);
        chk("ra_stall", {31'd0, stall}, 0);
        chk("ra_busaddr", bus.busAddr, 0);
        chk("ra_datain", dataIn, 0);
        chk("ra_dataaddr", dataAddr, 0);
        tick();
        chk("ra_no_pulses", {29'd0, loadDone, addrErr, busErr}, 0);
        bus.busWait = 1'b0; bus.busRData = 32'h5555AAAA;
        MemRead = 1'b1; addr = 32'h500;
        tick();
        MemRead = 1'b0;
        tick();
        chk("ra_post_loaddone", {31'd0, loadDone}, 1);
        chk("ra_post_datain", dataIn, 32'h5555AAAA);
        chk("ra_post_dataaddr", dataAddr, 32'h500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
